// File: rtl/fir_pkg.sv
// fir_pkg: register map, ap_ctrl bit positions and FSM states shared by the FIR engine
package fir_pkg;
  localparam logic [31:0] AP_CTRL   = 32'h00;
  localparam logic [31:0] DATA_LEN  = 32'h10;
  localparam logic [31:0] NUM_TAPS  = 32'h14;
  localparam logic [31:0] COEF_BASE = 32'h80;
  localparam int AP_START     = 0;
  localparam int AP_DONE      = 1;
  localparam int AP_IDLE      = 2;
  localparam int AP_TLAST_ERR = 3;
  typedef enum logic [2:0] {IDLE, WAIT_X, MAC, OUT, DONE} state_t;
endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed multiply-accumulate with clear-on-first-tap, output shift and
// optional clamping when FIR_SATURATE_EN is defined (plain wrap otherwise)
module fir_mac_unit #(
  parameter int pDATA_WIDTH = 32,
  parameter int pCOEF_WIDTH = 16,
  parameter int pACC_WIDTH  = 48,
  parameter int pOUT_SHIFT  = 0
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic                          en,
  input  logic                          first,
  input  logic signed [pDATA_WIDTH-1:0] x,
  input  logic signed [pCOEF_WIDTH-1:0] c,
  output logic signed [pDATA_WIDTH-1:0] y
);
  logic signed [pACC_WIDTH-1:0] acc, prod, sum;
  assign prod = pACC_WIDTH'(x) * pACC_WIDTH'(c);
  // y reflects the sum including the current product so the engine can register it on the last tap
  assign sum = (first ? '0 : acc) + prod;
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) acc <= '0;
    else if (en) acc <= sum;
`ifdef FIR_SATURATE_EN
  logic signed [pACC_WIDTH-1:0] sh;
  assign sh = sum >>> pOUT_SHIFT;
  assign y = (&sh[pACC_WIDTH-1:pDATA_WIDTH-1] | ~|sh[pACC_WIDTH-1:pDATA_WIDTH-1]) ? sh[pDATA_WIDTH-1:0]
           : {sh[pACC_WIDTH-1], {(pDATA_WIDTH-1){~sh[pACC_WIDTH-1]}}};
`else
  assign y = pDATA_WIDTH'(sum >>> pOUT_SHIFT);
`endif
endmodule

// File: rtl/fir_mch_engine.sv
// fir_mch_engine: multi-channel interleaved FIR, AXI-Lite config, AXI-Stream data in/out.
// Define FIR_SATURATE_EN to clamp outputs instead of wrapping.
module fir_mch_engine
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pCOEF_WIDTH = 16,
  parameter int pACC_WIDTH  = 48,
  parameter int pNUM_TAPS   = 16,
  parameter int pNUM_CH     = 2,
  parameter int pOUT_SHIFT  = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);
  localparam int TW = $clog2(pNUM_TAPS + 1);
  localparam int CW = pNUM_CH > 1 ? $clog2(pNUM_CH) : 1;

  state_t state, state_nx;
  logic signed [pCOEF_WIDTH-1:0] coef [pNUM_TAPS];
  logic signed [pDATA_WIDTH-1:0] dl [pNUM_CH][pNUM_TAPS];
  logic [pDATA_WIDTH-1:0] data_length, num_taps, out_cnt, rd_val;
  logic [TW-1:0] tap, nt_eff;
  logic [CW-1:0] ch;
  logic tlast_err;
  logic signed [pDATA_WIDTH-1:0] mac_x, y;
  logic signed [pCOEF_WIDTH-1:0] mac_c;
  logic [31:0] wa, ra;
  logic cfg_ok, wr_en, start, ss_hs, sm_hs, done_clr, last_tap, is_last;

  assign wa = 32'(awaddr);
  assign ra = 32'(araddr);
  assign wready = awready;
  assign cfg_ok = state == IDLE || state == DONE;
  assign wr_en = awready & awvalid & wvalid;
  assign start = wr_en && cfg_ok && wa == AP_CTRL && wdata[AP_START];
  assign ss_tready = state == WAIT_X;
  assign ss_hs = ss_tvalid & ss_tready;
  assign sm_hs = sm_tvalid & sm_tready;
  assign done_clr = arvalid && arready && ra == AP_CTRL && state == DONE;
  assign nt_eff = num_taps == '0 ? TW'(1) : num_taps > pDATA_WIDTH'(pNUM_TAPS) ? TW'(pNUM_TAPS) : TW'(num_taps);
  assign last_tap = tap == nt_eff - TW'(1);
  assign is_last = out_cnt == data_length - pDATA_WIDTH'(1);

  always_comb begin
    mac_x = '0;
    mac_c = '0;
    for (int i = 0; i < pNUM_TAPS; i++) begin
      if (tap == TW'(i)) mac_c = coef[i];
      for (int c = 0; c < pNUM_CH; c++)
        if (tap == TW'(i) && ch == CW'(c)) mac_x = dl[c][i];
    end
  end

  always_comb begin
    rd_val = '0;
    if (ra == AP_CTRL) begin
      rd_val[AP_DONE] = state == DONE;
      rd_val[AP_IDLE] = cfg_ok;
      rd_val[AP_TLAST_ERR] = tlast_err;
    end
    if (ra == DATA_LEN) rd_val = data_length;
    if (ra == NUM_TAPS) rd_val = num_taps;
    for (int i = 0; i < pNUM_TAPS; i++)
      if (ra == COEF_BASE + 32'(4 * i)) rd_val = pDATA_WIDTH'(coef[i]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = data_length == '0 ? DONE : WAIT_X;
      WAIT_X:  if (ss_hs) state_nx = MAC;
      MAC:     if (last_tap) state_nx = OUT;
      OUT:     if (sm_hs) state_nx = is_last ? DONE : WAIT_X;
      DONE:    state_nx = start ? (data_length == '0 ? DONE : WAIT_X) : done_clr ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      awready <= 1'b0;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      sm_tvalid <= 1'b0;
      sm_tdata <= '0;
      sm_tlast <= 1'b0;
      data_length <= '0;
      num_taps <= '0;
      out_cnt <= '0;
      tap <= '0;
      ch <= '0;
      tlast_err <= 1'b0;
      for (int i = 0; i < pNUM_TAPS; i++) coef[i] <= '0;
      for (int c = 0; c < pNUM_CH; c++)
        for (int i = 0; i < pNUM_TAPS; i++) dl[c][i] <= '0;
    end else begin
      awready <= awvalid & wvalid & ~awready;
      arready <= arvalid & ~arready & ~rvalid;
      if (arvalid & arready) begin
        rvalid <= 1'b1;
        rdata <= rd_val;
      end else if (rready) rvalid <= 1'b0;
      if (wr_en && cfg_ok) begin
        if (wa == DATA_LEN) data_length <= wdata;
        if (wa == NUM_TAPS) num_taps <= wdata;
        for (int i = 0; i < pNUM_TAPS; i++)
          if (wa == COEF_BASE + 32'(4 * i)) coef[i] <= wdata[pCOEF_WIDTH-1:0];
      end
      if (start) begin
        ch <= '0;
        out_cnt <= '0;
        tlast_err <= 1'b0;
        for (int c = 0; c < pNUM_CH; c++)
          for (int i = 0; i < pNUM_TAPS; i++) dl[c][i] <= '0;
      end
      if (ss_hs) begin
        tap <= '0;
        if (ss_tlast && !is_last) tlast_err <= 1'b1;
        for (int c = 0; c < pNUM_CH; c++)
          if (ch == CW'(c)) begin
            dl[c][0] <= ss_tdata;
            for (int i = 1; i < pNUM_TAPS; i++) dl[c][i] <= dl[c][i-1];
          end
      end
      if (state == MAC) begin
        tap <= tap + TW'(1);
        if (last_tap) begin
          sm_tvalid <= 1'b1;
          sm_tdata <= y;
          sm_tlast <= is_last;
        end
      end
      if (sm_hs) begin
        sm_tvalid <= 1'b0;
        sm_tlast <= 1'b0;
        out_cnt <= out_cnt + pDATA_WIDTH'(1);
        ch <= ch == CW'(pNUM_CH - 1) ? '0 : ch + CW'(1);
      end
    end

  fir_mac_unit #(
    .pDATA_WIDTH(pDATA_WIDTH),
    .pCOEF_WIDTH(pCOEF_WIDTH),
    .pACC_WIDTH (pACC_WIDTH),
    .pOUT_SHIFT (pOUT_SHIFT)
  ) u_mac (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .en        (state == MAC),
    .first     (tap == '0),
    .x         (mac_x),
    .c         (mac_c),
    .y         (y)
  );
endmodule

// File: tb/tb_fir_mch_engine.sv
// tb_fir_mch_engine: directed bench with a sum-of-products model of the interleaved FIR
module tb_fir_mch_engine;
  localparam int NT = 16;
  localparam int NCH = 2;

  logic axis_clk = 0, axis_rst_n = 0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic ss_tvalid = 0, ss_tlast = 0, sm_tready = 0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, ss_tdata = '0;
  logic awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
  logic [31:0] rdata, sm_tdata;

  fir_mch_engine dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc++;

  int checks = 0, errors = 0;
  int cf [NT];
  int xs [$];
  logic [31:0] got [$];
  int hs_cyc = 0;
  int early = -1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    for (int t = 0; t < 20 && !awready; t++) @(negedge axis_clk);
    chk("awready", {31'd0, awready}, 1);
    @(negedge axis_clk);
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    araddr = a; arvalid = 1;
    for (int t = 0; t < 20 && !arready; t++) @(negedge axis_clk);
    chk("arready", {31'd0, arready}, 1);
    @(negedge axis_clk);
    arvalid = 0;
    for (int t = 0; t < 20 && !rvalid; t++) @(negedge axis_clk);
    chk("rvalid", {31'd0, rvalid}, 1);
    d = rdata; rready = 1;
    @(negedge axis_clk);
    rready = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(name, d, exp);
  endtask

  task automatic wr_coef(input int i, input logic [31:0] v);
    logic [15:0] lo;
    axi_write(12'(32'h80 + 4 * i), v);
    lo = v[15:0];
    cf[i] = int'($signed(lo));
  endtask

  function automatic int ntf(input int raw);
    return raw == 0 ? 1 : raw > NT ? NT : raw;
  endfunction

  // y for output j: channel j%NCH, that channel's m-th sample, convolved with the first nt coefs
  function automatic logic [31:0] model_y(input int j, input int nt);
    longint acc = 0;
    int ch = j % NCH, m = j / NCH;
    for (int k = 0; k < nt; k++)
      if (m - k >= 0) acc += longint'(cf[k]) * longint'(xs[(m - k) * NCH + ch]);
`ifdef FIR_SATURATE_EN
    if (acc > 64'sh7FFFFFFF) acc = 64'sh7FFFFFFF;
    if (acc < -64'sh80000000) acc = -64'sh80000000;
`endif
    return acc[31:0];
  endfunction

  task automatic run(input int nt_raw, input bit stall, input bit busy);
    int n = xs.size(), nt = ntf(nt_raw);
    got.delete();
    axi_write(12'h00, 1);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          ss_tvalid = 1; ss_tdata = xs[i]; ss_tlast = (i == n - 1) || (i == early);
          for (int t = 0; t < 400 && !ss_tready; t++) @(negedge axis_clk);
          chk("ss_tready", {31'd0, ss_tready}, 1);
          if (!ss_tready) break;
          hs_cyc = cyc;
          @(negedge axis_clk);
        end
        ss_tvalid = 0; ss_tlast = 0;
      end
      begin
        for (int j = 0; j < n; j++) begin
          logic [31:0] held;
          for (int t = 0; t < 400 && !sm_tvalid; t++) @(negedge axis_clk);
          chk("sm_tvalid", {31'd0, sm_tvalid}, 1);
          if (!sm_tvalid) break;
          chk("latency", cyc - hs_cyc, nt + 1);
          held = sm_tdata;
          if (stall)
            repeat (5) begin
              @(negedge axis_clk);
              chk("stall_hold", sm_tdata, held);
              chk("stall_flags", {30'd0, sm_tvalid, ss_tready}, 2);
            end
          chk("y", sm_tdata, model_y(j, nt));
          chk("tlast", {31'd0, sm_tlast}, {31'd0, j == n - 1});
          got.push_back(sm_tdata);
          sm_tready = 1;
          @(negedge axis_clk);
          sm_tready = 0;
        end
      end
      begin
        if (busy) begin
          @(negedge axis_clk);
          axi_write(12'h80, 7);
          axi_write(12'h00, 1);
          axi_write(12'h10, 99);
          chk("busy_ready", {31'd0, ss_tready}, 0);
        end
      end
    join
    @(negedge axis_clk);
    chk("no_extra", {31'd0, sm_tvalid}, 0);
  endtask

  int e1 [6] = '{1, 2, 5, 8, 14, 20};
  int e2 [6] = '{10, 100, 3, 5, 7, -15};
  int e6 [4] = '{1, 2, 2, 2};

  initial begin
    for (int i = 0; i < NT; i++) cf[i] = 0;
    repeat (3) @(negedge axis_clk);
    chk("rst_flags", {25'd0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_tdata", sm_tdata, 0);
    axis_rst_n = 1;
    @(negedge axis_clk);
    rd_chk("idle_ctrl", 12'h00, 32'h4);

    for (int i = 0; i < 4; i++) wr_coef(i, i + 1);
    axi_write(12'h14, 4);
    axi_write(12'h10, 6);
    xs = '{1, 2, 3, 4, 5, 6};
    run(4, 0, 0);
    chk("t1_cnt", got.size(), 6);
    for (int j = 0; j < 6; j++) chk("t1_lit", got[j], e1[j]);
    rd_chk("t1_done", 12'h00, 32'h6);
    rd_chk("t1_idle", 12'h00, 32'h4);
    rd_chk("coef3", 12'h8C, 4);
    rd_chk("ntaps_rd", 12'h14, 4);
    rd_chk("unmapped", 12'h20, 0);

    wr_coef(0, 1);
    wr_coef(1, 32'hFFFF_FFFF);
    axi_write(12'h14, 2);
    rd_chk("coef1_neg", 12'h84, 32'hFFFF_FFFF);
    xs = '{10, 100, 13, 105, 20, 90};
    run(2, 0, 0);
    chk("t2_cnt", got.size(), 6);
    for (int j = 0; j < 6; j++) chk("t2_lit", got[j], e2[j]);

    run(2, 1, 0);
    chk("t3_cnt", got.size(), 6);
    for (int j = 0; j < 6; j++) chk("t3_lit", got[j], e2[j]);
    rd_chk("t3_done", 12'h00, 32'h6);

    axi_write(12'h14, 20);
    axi_write(12'h10, 1);
    xs = '{5};
    run(20, 0, 1);
    chk("t4_lit", got[0], 5);
    rd_chk("coef0_kept", 12'h80, 1);
    rd_chk("len_kept", 12'h10, 1);

    axi_write(12'h14, 2);
    axi_write(12'h10, 4);
    xs = '{1, 2, 3, 4};
    early = 1;
    run(2, 0, 0);
    early = -1;
    chk("t6_cnt", got.size(), 4);
    for (int j = 0; j < 4; j++) chk("t6_lit", got[j], e6[j]);
    rd_chk("tlast_err", 12'h00, 32'hE);

    axi_write(12'h10, 0);
    axi_write(12'h00, 1);
    chk("len0_ready", {31'd0, ss_tready}, 0);
    rd_chk("len0_done", 12'h00, 32'h6);
    rd_chk("len0_idle", 12'h00, 32'h4);

    axi_write(12'h14, 0);
    wr_coef(0, 2);
    axi_write(12'h10, 1);
    xs = '{32'h7FFF_FFFF};
    run(0, 0, 0);
`ifdef FIR_SATURATE_EN
    chk("ovf_lit", got[0], 32'h7FFF_FFFF);
`else
    chk("ovf_lit", got[0], 32'hFFFF_FFFE);
`endif

    axi_write(12'h14, 16);
    axi_write(12'h10, 2);
    axi_write(12'h00, 1);
    ss_tvalid = 1; ss_tdata = 9;
    @(negedge axis_clk);
    ss_tvalid = 0;
    repeat (3) @(negedge axis_clk);
    chk("mac_busy", {31'd0, ss_tready}, 0);
    axis_rst_n = 0;
    #1;
    chk("arst_flags", {25'd0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_tdata", sm_tdata, 0);
    @(negedge axis_clk);
    axis_rst_n = 1;
    @(negedge axis_clk);
    rd_chk("arst_coef0", 12'h80, 0);
    rd_chk("arst_coef2", 12'h88, 0);
    rd_chk("arst_ntaps", 12'h14, 0);
    rd_chk("arst_ctrl", 12'h00, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
